uartrx_fifo: RTL and testbench

// - Buffered front end for 'uartrx'; sits between 'uartrx' and the I/O mapping in 'ramio'.
// - Takes over the go / data_ready handshake with 'uartrx' and pushes each received byte

---
 rtl/fifo_sync.sv | 55 +++++
 rtl/uartrx_fifo.sv | 79 +++++++
 tb/tb_uartrx_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fifo_sync.sv
// Generic synchronous first-word-fall-through FIFO with registered count.
// The head reads as zero whenever the FIFO is empty.
module fifo_sync #(
    parameter int DataBitWidth  = 8,
    parameter int DepthBitWidth = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DataBitWidth-1:0] push_data,
    output logic [DataBitWidth-1:0] head,
    output logic [DepthBitWidth:0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int Depth = 1 << DepthBitWidth;

    logic [DataBitWidth-1:0]  mem [Depth];
    logic [DepthBitWidth-1:0] wr_ptr;
    logic [DepthBitWidth-1:0] rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (DepthBitWidth + 1)'(Depth));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uartrx_fifo.sv
// Buffered front end for uartrx: owns the go/data_ready handshake, queues
// received bytes in a FIFO and tracks a sticky overflow flag for dropped bytes.
module uartrx_fifo #(
    parameter int DepthBitWidth = 4
) (
    input  logic                   rst_n,
    input  logic                   clk,
    output logic                   uartrx_go,
    input  logic [7:0]             uartrx_data,
    input  logic                   uartrx_data_ready,
    input  logic                   rd_en,
    output logic [7:0]             data_out,
    output logic                   empty,
    output logic                   full,
    output logic [DepthBitWidth:0] count,
    output logic                   overflow,
    input  logic                   clear_overflow
);

    typedef enum logic {
        Receive,
        Ack
    } rx_state_t;

    rx_state_t state;
    rx_state_t state_next;
    logic      push;
    logic      drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= Receive;
        else        state <= state_next;
    end

    // Ack drops go for one cycle so uartrx sees each byte consumed exactly once.
    always_comb begin
        state_next = state;
        uartrx_go  = 1'b1;
        push       = 1'b0;
        case (state)
            Receive: begin
                if (uartrx_data_ready) begin
                    push       = 1'b1;
                    state_next = Ack;
                end
            end
            Ack: begin
                uartrx_go  = 1'b0;
                state_next = Receive;
            end
            default: state_next = Receive;
        endcase
    end

    assign drop = push && full && !rd_en;

    // A new drop outranks a simultaneous clear so no loss goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
        else if (clear_overflow) overflow <= 1'b0;
    end

    fifo_sync #(
        .DataBitWidth (8),
        .DepthBitWidth(DepthBitWidth)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (rd_en),
        .push_data(uartrx_data),
        .head     (data_out),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

endmodule

// File: tb/tb_uartrx_fifo.sv
// Self-checking bench for uartrx_fifo: directed steps plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_uartrx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uartrx_go;
    logic [7:0] uartrx_data = 8'h00;
    logic       uartrx_data_ready = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clear_overflow = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    byte unsigned m_q[$];
    bit           m_ovf = 1'b0;
    bit           m_busy = 1'b0;

    uartrx_fifo #(.DepthBitWidth(4)) dut (
        .rst_n            (rst_n),
        .clk              (clk),
        .uartrx_go        (uartrx_go),
        .uartrx_data      (uartrx_data),
        .uartrx_data_ready(uartrx_data_ready),
        .rd_en            (rd_en),
        .data_out         (data_out),
        .empty            (empty),
        .full             (full),
        .count            (count),
        .overflow         (overflow),
        .clear_overflow   (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        byte unsigned head;
        head = (m_q.size() == 0) ? 8'h00 : m_q[0];
        chk({tag, ".count"},    32'(count),     32'(m_q.size()));
        chk({tag, ".empty"},    32'(empty),     32'(m_q.size() == 0));
        chk({tag, ".full"},     32'(full),      32'(m_q.size() == 16));
        chk({tag, ".data_out"}, 32'(data_out),  32'(head));
        chk({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
        chk({tag, ".go"},       32'(uartrx_go), 32'(!m_busy));
    endtask

    // One clock: apply inputs, advance the model at the edge, then compare.
    task automatic cycle(input string tag, input bit dr, input byte unsigned d,
                         input bit rd, input bit clr);
        bit accept;
        bit drop;
        uartrx_data_ready = dr;
        uartrx_data       = d;
        rd_en             = rd;
        clear_overflow    = clr;
        @(posedge clk);
        accept = dr && !m_busy;
        drop   = accept && (m_q.size() == 16) && !rd;
        if (rd && m_q.size() > 0) void'(m_q.pop_front());
        if (accept && !drop) m_q.push_back(d);
        if (drop)     m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_busy = accept;
        #1;
        uartrx_data_ready = 1'b0;
        rd_en             = 1'b0;
        clear_overflow    = 1'b0;
        check_all(tag);
    endtask

    task automatic send_byte(input string tag, input byte unsigned d);
        cycle(tag, 1'b1, d, 1'b0, 1'b0);
        cycle(tag, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_busy = 1'b0;
    endtask

    initial begin
        // 1. Reset values
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.go_const", 32'(uartrx_go), 32'd1);
        rst_n = 1'b1;
        cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // 2. Single byte and its Ack cycle
        cycle("one.push", 1'b1, 8'h41, 1'b0, 1'b0);
        chk("one.go_low", 32'(uartrx_go), 32'd0);
        chk("one.head", 32'(data_out), 32'h41);
        cycle("one.ack", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("one.go_high", 32'(uartrx_go), 32'd1);
        cycle("one.pop", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("one.after_pop", 32'(data_out), 32'h00);

        // 3. Fill, overflow (including set-beats-clear), drain, extra pop
        for (int i = 1; i <= 16; i++) send_byte("fill", 8'(i));
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd16);
        send_byte("ovf", 8'h11);
        chk("ovf.flag", 32'(overflow), 32'd1);
        cycle("ovf_clr_set", 1'b1, 8'h12, 1'b0, 1'b1);
        chk("ovf_clr_set.flag", 32'(overflow), 32'd1);
        cycle("ovf.ack", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            chk("drain.order", 32'(data_out), 32'(i));
            cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        cycle("drain.extra", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain.zero", 32'(data_out), 32'h00);
        cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr.flag", 32'(overflow), 32'd0);

        // 4. Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) send_byte("fill2", 8'(8'h80 + i));
        cycle("full_pushpop", 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_pushpop.count", 32'(count), 32'd16);
        chk("full_pushpop.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain2.last", 32'(data_out), 32'h00);

        // 5. Wrap-around with interleaved push/pop
        for (int i = 0; i < 40; i++) begin
            cycle("wrap.push", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
            chk("wrap.head", 32'(data_out), 32'(8'h20 + i));
            cycle("wrap.pop", 1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap.bound", 32'(count <= 5'd3), 32'd1);
        end

        // Random traffic
        for (int i = 0; i < 600; i++)
            cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));

        // 6. Asynchronous reset while count=5 and in Ack
        cycle("pre_rst", 1'b0, 8'h00, 1'b1, 1'b1);
        while (m_q.size() > 0) cycle("pre_rst.drain", 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_byte("rst_fill", 8'(8'h60 + i));
        cycle("rst_fill.last", 1'b1, 8'h64, 1'b0, 1'b0);
        chk("rst_pre.count", 32'(count), 32'd5);
        chk("rst_pre.go", 32'(uartrx_go), 32'd0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_next");
        rst_n = 1'b1;
        send_byte("post_rst", 8'h5A);
        chk("post_rst.head", 32'(data_out), 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
